// File: rtl/approx_eval_pkg.sv
// Shared state encoding and width helpers for the approximate-adder error monitor.
package approx_eval_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Signed error width: holds approx (w+1 bits) minus exact (w+1 bits).
    function automatic int unsigned err_w(input int unsigned w);
        return w + 2;
    endfunction

    // Width of err^2, computed from |err| which fits in w+1 bits.
    function automatic int unsigned sq_w(input int unsigned w);
        return 2 * w + 2;
    endfunction

    // SSE accumulator: one square per counted beat, so it cannot overflow.
    function automatic int unsigned acc_w(input int unsigned w, input int unsigned c);
        return sq_w(w) + c;
    endfunction

    // Signed bias accumulator width.
    function automatic int unsigned sum_w(input int unsigned w, input int unsigned c);
        return c + w + 2;
    endfunction

endpackage

// File: rtl/approx_err_datapath.sv
// Combinational exact sum and error terms for one (a, b, approx) sample.
module approx_err_datapath
    import approx_eval_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]                a_i,
    input  logic [WIDTH-1:0]                b_i,
    input  logic [WIDTH:0]                  approx_i,
    output logic signed [err_w(WIDTH)-1:0]  err_c,
    output logic [WIDTH:0]                  abs_err_c,
    output logic                            mismatch_c
);

    localparam int unsigned EW = err_w(WIDTH);

    logic [WIDTH:0] exact;

    // Exact sum, signed error, magnitude and mismatch flag.
    always_comb begin
        exact      = (WIDTH+1)'(a_i) + (WIDTH+1)'(b_i);
        err_c      = $signed(EW'(approx_i)) - $signed(EW'(exact));
        abs_err_c  = err_c[EW-1] ? (WIDTH+1)'(-err_c) : (WIDTH+1)'(err_c);
        mismatch_c = (approx_i != exact);
    end

endmodule

// File: rtl/approx_adder_error_monitor.sv
// Run controller, two-stage error pipeline and metric accumulators.
module approx_adder_error_monitor
    import approx_eval_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 17,
    parameter int unsigned ACC_W = acc_w(WIDTH, CNT_W)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [CNT_W-1:0]                num_samples,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_a,
    input  logic [WIDTH-1:0]                in_b,
    input  logic [WIDTH:0]                  in_approx,
    output logic                            busy,
    output logic                            done,
    output logic [CNT_W-1:0]                err_count,
    output logic [ACC_W-1:0]                sse,
    output logic [sum_w(WIDTH, CNT_W)-1:0]  sum_err,
    output logic [WIDTH:0]                  max_abs_err
);

    localparam int unsigned EW  = err_w(WIDTH);
    localparam int unsigned SW  = sq_w(WIDTH);
    localparam int unsigned SEW = sum_w(WIDTH, CNT_W);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       num_q, num_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   s1_valid_q, s2_valid_q;
    logic signed [EW-1:0]   s1_err_q;
    logic [WIDTH:0]         s1_abs_q;
    logic                   s1_mis_q;

    logic [CNT_W-1:0]       err_count_q, err_count_d;
    logic [ACC_W-1:0]       sse_q, sse_d;
    logic signed [SEW-1:0]  sum_err_q, sum_err_d;
    logic [WIDTH:0]         max_q, max_d;

    logic signed [EW-1:0]   err_c;
    logic [WIDTH:0]         abs_err_c;
    logic                   mismatch_c;
    logic                   accept_c;
    logic [SW-1:0]          sq_c;

    assign accept_c = in_valid & in_ready_q;

    approx_err_datapath #(.WIDTH(WIDTH)) u_dp (
        .a_i        (in_a),
        .b_i        (in_b),
        .approx_i   (in_approx),
        .err_c      (err_c),
        .abs_err_c  (abs_err_c),
        .mismatch_c (mismatch_c)
    );

    // Next state, beat counter and registered handshake/status flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    num_d   = num_samples;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = (num_q == '0) ? DRAIN : RUN;
            end
            RUN: begin
                if (accept_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == num_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == RUN);
        busy_d     = (state_d == CLEAR) || (state_d == RUN) || (state_d == DRAIN);
        done_d     = (state_d == DONE);
    end

    // Stage-2 metric update from the stage-1 error registers.
    always_comb begin
        sq_c        = SW'(s1_abs_q) * SW'(s1_abs_q);
        err_count_d = err_count_q;
        sse_d       = sse_q;
        sum_err_d   = sum_err_q;
        max_d       = max_q;
        if (state_q == CLEAR) begin
            err_count_d = '0;
            sse_d       = '0;
            sum_err_d   = '0;
            max_d       = '0;
        end else if (s1_valid_q) begin
            err_count_d = err_count_q + CNT_W'(s1_mis_q);
            sse_d       = sse_q + ACC_W'(sq_c);
            sum_err_d   = sum_err_q + SEW'(s1_err_q);
            if (s1_abs_q > max_q) max_d = s1_abs_q;
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            num_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            num_q      <= num_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Pipeline stages and metric accumulators; the pipe never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s1_err_q    <= '0;
            s1_abs_q    <= '0;
            s1_mis_q    <= 1'b0;
            err_count_q <= '0;
            sse_q       <= '0;
            sum_err_q   <= '0;
            max_q       <= '0;
        end else begin
            s1_valid_q  <= accept_c;
            s2_valid_q  <= s1_valid_q;
            s1_err_q    <= err_c;
            s1_abs_q    <= abs_err_c;
            s1_mis_q    <= mismatch_c;
            err_count_q <= err_count_d;
            sse_q       <= sse_d;
            sum_err_q   <= sum_err_d;
            max_q       <= max_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_count   = err_count_q;
    assign sse         = sse_q;
    assign sum_err     = sum_err_q;
    assign max_abs_err = max_q;

endmodule
